led_decoder: RTL

Receiver for the six-digit multiplexed seven-segment bus produced by the team's LED encoder. It samples the active-low segment lines and the one-hot digit select, decodes each strobed digit back to BCD and assembles complete frames. It publishes a six-digit value only after the same frame has been seen a programmable number of times in a row. It sits on the board-to-board display link and in the clock-task benches as a self-checking monitor.

---
 rtl/led_decoder_pkg.sv | 32 +++
 rtl/led_decoder_seg7_to_bcd.sv | 30 +++
 rtl/led_decoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/led_decoder_pkg.sv
// Shared definitions for the seven-segment display link (encoder and decoder).
package led_decoder_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] digit_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Strobe tracking FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } dec_state_t;

  // True when exactly one bit of the digit select is set.
  function automatic logic is_onehot6(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/led_decoder_seg7_to_bcd.sv
// Combinational active-low seven-segment pattern to BCD decoder.
// Any pattern outside the ten legal digits raises o_invalid and yields 0.
module seg7_to_bcd
  import led_decoder_pkg::*;
(
  input  logic [6:0] i_seg,
  output digit_t     o_bcd,
  output logic       o_invalid
);

  // Table lookup of the ten legal patterns.
  always_comb begin
    o_bcd     = 4'd0;
    o_invalid = 1'b0;
    case (i_seg)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/led_decoder.sv
// Receiver for the six-digit multiplexed seven-segment bus. Synchronizes the
// segment and digit lines, captures each strobed digit once it has been
// stable for SETTLE samples, assembles frames and publishes a value once the
// same frame has been seen STABLE_FRAMES times in a row.
module led_decoder
  import led_decoder_pkg::*;
#(
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT       = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig,
  output digit_t [NUM_DIGITS-1:0] value,
  output logic                    valid,
  output logic                    frame_done,
  output logic                    err,
  output logic [1:0]              o_dbg_state
);

  localparam int SCW = $clog2(SETTLE + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [SCW-1:0] SETTLE_FULL = SCW'(SETTLE);
  localparam logic [TW-1:0]  TIMEOUT_V   = TW'(TIMEOUT);
  localparam logic [3:0]     STABLE_V    = 4'(STABLE_FRAMES);
  localparam logic [3:0]     MATCH_MAX   = 4'd15;

  // Synchronizer stages plus the previous synchronized sample for change detect.
  logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NUM_DIGITS-1:0] r_dig_s1, r_dig_s2, r_dig_prev;

  // Strobe FSM.
  dec_state_t            r_state;
  logic [SCW-1:0]        r_cnt;
  logic                  r_err;

  // Frame assembly.
  digit_t [NUM_DIGITS-1:0] r_scratch;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic                    r_bad;

  // Stability / publication.
  digit_t [NUM_DIGITS-1:0] r_prev_good;
  digit_t [NUM_DIGITS-1:0] r_value;
  logic [3:0]              r_match;
  logic                    r_valid;
  logic                    r_frame_done;
  logic [TW-1:0]           r_to;

  // Combinational decisions.
  digit_t                w_bcd;
  logic                  w_invalid;
  logic                  w_change;
  logic                  w_onehot;
  logic                  w_multi_new;
  logic                  w_restart;
  logic                  w_capture;
  logic                  w_err_ev;
  logic [NUM_DIGITS-1:0] w_seen_set;
  logic                  w_close;
  logic                  w_same;
  logic [3:0]            w_match_nx;
  logic                  w_load;
  dec_state_t            w_state_nx;
  logic [SCW-1:0]        w_cnt_nx;

  seg7_to_bcd u_seg7_to_bcd (
    .i_seg     (r_seg_s2),
    .o_bcd     (w_bcd),
    .o_invalid (w_invalid)
  );

  assign w_change    = (r_seg_s2 != r_seg_prev) || (r_dig_s2 != r_dig_prev);
  assign w_onehot    = is_onehot6(r_dig_s2);
  // A multi-hot select reports once when it first appears or changes shape.
  assign w_multi_new = !w_onehot && (r_dig_s2 != '0) && (r_dig_s2 != r_dig_prev);
  assign w_err_ev    = (w_capture && w_invalid) || w_multi_new;
  // The select is one-hot whenever a capture happens, so it doubles as the mask.
  assign w_seen_set  = (w_capture && !w_invalid) ? r_dig_s2 : '0;
  assign w_close     = (r_seen == '1);
  assign w_same      = (r_scratch == r_prev_good);
  assign w_match_nx  = !w_same ? 4'd1 :
                       (r_match == MATCH_MAX) ? MATCH_MAX : 4'(r_match + 4'd1);
  assign w_load      = !r_bad && (w_match_nx == STABLE_V) &&
                       ((r_scratch != r_value) || !r_valid);

  assign value       = r_value;
  assign valid       = r_valid;
  assign frame_done  = r_frame_done;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  // Two-flop synchronizer and one-sample history of the synchronized pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg_s1   <= 7'h7F;
      r_seg_s2   <= 7'h7F;
      r_seg_prev <= 7'h7F;
      r_dig_s1   <= '0;
      r_dig_s2   <= '0;
      r_dig_prev <= '0;
    end else begin
      r_seg_s1   <= seg;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_dig_s1   <= dig;
      r_dig_s2   <= r_dig_s1;
      r_dig_prev <= r_dig_s2;
    end
  end

  // Next-state and capture decision for the strobe FSM.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    w_restart  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_restart = w_onehot;
      end
      ST_SETTLE: begin
        if (w_change) begin
          if (w_onehot) w_restart  = 1'b1;
          else          w_state_nx = ST_IDLE;
        end else if (r_cnt == SETTLE_LAST) begin
          w_capture  = 1'b1;
          w_state_nx = ST_HOLD;
          w_cnt_nx   = SETTLE_FULL;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_change) begin
          if (w_onehot) w_restart  = 1'b1;
          else          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // A new one-hot sample is the first of SETTLE; SETTLE=1 captures at once.
    if (w_restart) begin
      if (SETTLE == 1) begin
        w_capture  = 1'b1;
        w_state_nx = ST_HOLD;
        w_cnt_nx   = SETTLE_FULL;
      end else begin
        w_state_nx = ST_SETTLE;
        w_cnt_nx   = SCW'(1);
      end
    end
  end

  // Strobe FSM state, settle counter and registered error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_ev;
    end
  end

  // Frame assembly: scratch digits, seen mask and bad-frame mark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scratch <= '0;
      r_seen    <= '0;
      r_bad     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_seen_set[i]) r_scratch[i] <= w_bcd;
      end
      r_seen <= (r_seen & {NUM_DIGITS{!w_close}}) | w_seen_set;
      r_bad  <= (r_bad & !w_close) | w_err_ev;
    end
  end

  // Frame close handling, stability matching, publication and timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_good  <= '0;
      r_value      <= '0;
      r_match      <= 4'd0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_to         <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_close) begin
        r_to <= '0;
        if (r_bad) begin
          r_match <= 4'd0;
        end else begin
          r_match     <= w_match_nx;
          r_prev_good <= r_scratch;
          if (w_load) begin
            r_value      <= r_scratch;
            r_valid      <= 1'b1;
            r_frame_done <= 1'b1;
          end
        end
      end else if (r_to == TIMEOUT_V) begin
        r_valid <= 1'b0;
        r_match <= 4'd0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end

endmodule
